wb_copy_master: RTL and testbench
=================================

WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles waited for ack/err per bus phase before abort (1..65535).
REQ-002 SHALL have port clk_i  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  one-cycle copy request, sampled only in IDLE.
REQ-005 SHALL have port src_adr_i  input  32  source byte address; bits [1:0] ignored, treated as 0.
REQ-006 SHALL have port dst_adr_i  input  32  destination byte address; bits [1:0] ignored, treated as 0.
REQ-007 SHALL have port len_i  input  16  number of 32-bit words to copy.
REQ-008 SHALL have port busy_o  output  1  high from the cycle after accepted start until DONE/ABORT.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse on completion, success or abort.
REQ-010 SHALL have port err_o  output  1  sticky abort flag, cleared by next accepted start.
REQ-011 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master controls.
REQ-012 SHALL have ports wb_adr_o  output  32, wb_sel_o  output  4, wb_dat_o  output  32  master address, byte select, write data.
REQ-013 SHALL have ports wb_ack_i  input  1, wb_err_i  input  1, wb_dat_i  input  32  slave responses and read data.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, DONE, ABORT.
REQ-015 IDLE: start_i=1 with len_i!=0 SHALL latch src, dst, len and enter READ next cycle; len_i=0 SHALL go directly to DONE (no bus cycle).
REQ-016 READ: SHALL drive cyc=stb=1, we=0, sel=4'hF, adr=current source address; on ack SHALL capture wb_dat_i into a holding register and enter WRITE.
REQ-017 WRITE: SHALL drive cyc=stb=1, we=1, sel=4'hF, adr=current destination, dat=holding register; on ack SHALL decrement remaining count, add 4 to both addresses, and enter READ if remaining>0 else DONE.
REQ-018 All Wishbone outputs SHALL be registered; cyc/stb SHALL remain high across READ->WRITE->READ transitions; adr/we/dat SHALL change only on the edge where ack is sampled.
REQ-019 Addresses SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-020 wb_err_i=1 in READ or WRITE SHALL enter ABORT, taking priority over simultaneous wb_ack_i.
REQ-021 A per-phase counter SHALL reset on entering each phase; reaching TIMEOUT cycles without ack/err SHALL enter ABORT.
REQ-022 ABORT SHALL drop cyc/stb/we next cycle, set err_o, pulse done_o, return to IDLE.
REQ-023 DONE SHALL hold cyc/stb/we low, pulse done_o for one cycle, return to IDLE.
REQ-024 start_i while busy SHALL be ignored.
REQ-025 Against a slave acking one cycle after stb and deasserting ack for one cycle, each word SHALL take 4 clk cycles.

Reset
REQ-026 rst_i SHALL asynchronously force IDLE and clear cyc, stb, we, busy_o, done_o, err_o, counters; adr/dat/sel SHALL reset to 0.
REQ-027 Reset mid-transfer SHALL drop cyc/stb immediately; no partial state survives.

Structure
REQ-028 FSM state encoding and the word-increment constant (4) SHALL reside in a shared package wb_pkg.
REQ-029 The datapath SHALL be one module; the timeout counter MAY be a sub-module wb_timeout_cnt.

Verification
REQ-030 src=0x000, dst=0x400, len=4 against wb_ram_top preloaded 0x11111111..0x44444444 -> dst words match, done_o after 16 bus cycles, err_o=0.
REQ-031 len=0 start -> done_o two cycles later, wb_cyc_o never asserted.
REQ-032 wb_err_i asserted on second READ -> ABORT, err_o=1, cyc low next cycle, one word written.
REQ-033 Slave never acks, TIMEOUT=8 -> ABORT after 8 cycles in READ, err_o=1.
REQ-034 src=0xFFFFFFFC, len=2 -> second read address 0x00000000.
REQ-035 rst_i asserted during WRITE -> cyc/stb/busy low within same cycle; subsequent start copies correctly.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone word-copy master: FSM encoding,
// word stride and address alignment helper.
package wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE,
      ST_ABORT
   } state_t;

   localparam logic [31:0] WORD_INC = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] adr);
      return {adr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// Wishbone classic bus between the copy master and a memory slave.
interface wb_copy_master_if;

   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic [31:0] wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_ack_i, wb_err_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_ack_i, wb_err_i, wb_dat_i
   );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Per-phase watchdog: counts cycles spent waiting in one bus phase and
// flags expiry once TIMEOUT cycles have elapsed without a response.
module wb_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

   logic [15:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en && !o_expired)
         r_cnt <= r_cnt + 16'd1;
   end

   assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone master copying len_i 32-bit words from src to dst, one
// read/write pair per word, with error and per-phase timeout abort.
module wb_copy_master
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_adr_i,
   input  logic [31:0]      dst_adr_i,
   input  logic [15:0]      len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   wb_copy_master_if.master wb
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [15:0] r_len;
   logic        w_accept;
   logic        w_phase;
   logic        w_bus_next;
   logic        w_expired;

   assign w_accept   = (r_state == ST_IDLE) && start_i;
   assign w_phase    = (r_state == ST_READ) || (r_state == ST_WRITE);
   assign w_bus_next = (w_next == ST_READ) || (w_next == ST_WRITE);

   wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_clr     (w_next != r_state),
      .i_en      (w_phase),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // NOTE: w_next gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:
            if (start_i) w_next = (len_i == 16'd0) ? ST_DONE : ST_READ;
         ST_READ:
            if (wb.wb_err_i)      w_next = ST_ABORT;
            else if (wb.wb_ack_i) w_next = ST_WRITE;
            else if (w_expired)   w_next = ST_ABORT;
         ST_WRITE:
            if (wb.wb_err_i)      w_next = ST_ABORT;
            else if (wb.wb_ack_i) w_next = (r_len == 16'd1) ? ST_DONE : ST_READ;
            else if (w_expired)   w_next = ST_ABORT;
         ST_DONE, ST_ABORT:
            w_next = ST_IDLE;
         default:
            w_next = ST_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state, so they line up with
   // r_state and only move on the edge that samples ack/err.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_adr_o <= '0;
         wb.wb_sel_o <= '0;
         wb.wb_dat_o <= '0;
         r_src       <= '0;
         r_dst       <= '0;
         r_len       <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         wb.wb_cyc_o <= w_bus_next;
         wb.wb_stb_o <= w_bus_next;
         wb.wb_sel_o <= w_bus_next ? 4'hF : 4'h0;
         busy_o      <= (w_next != ST_IDLE);
         done_o      <= (r_state == ST_DONE) || (r_state == ST_ABORT);

         if (r_state == ST_ABORT)
            err_o <= 1'b1;
         else if (w_accept)
            err_o <= 1'b0;

         case (r_state)
            ST_IDLE:
               if (w_next == ST_READ) begin
                  r_src       <= word_align(src_adr_i);
                  r_dst       <= word_align(dst_adr_i);
                  r_len       <= len_i;
                  wb.wb_adr_o <= word_align(src_adr_i);
                  wb.wb_we_o  <= 1'b0;
               end
            ST_READ:
               if (w_next == ST_WRITE) begin
                  wb.wb_dat_o <= wb.wb_dat_i;
                  wb.wb_adr_o <= r_dst;
                  wb.wb_we_o  <= 1'b1;
               end
            ST_WRITE:
               if ((w_next == ST_READ) || (w_next == ST_DONE)) begin
                  r_src      <= r_src + WORD_INC;
                  r_dst      <= r_dst + WORD_INC;
                  r_len      <= r_len - 16'd1;
                  wb.wb_we_o <= 1'b0;
                  if (w_next == ST_READ) wb.wb_adr_o <= r_src + WORD_INC;
               end
            default: ;
         endcase

         if (!w_bus_next) wb.wb_we_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench: table of copy jobs plus abort, timeout, wrap and
// mid-transfer reset sequences against a one-wait-state memory slave.
module tb_wb_copy_master;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } xfer_t;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] len;
      int          exp_done;
      int          exp_cyc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_adr;
   logic [31:0] dst_adr;
   logic [15:0] len_in;
   logic        busy;
   logic        done;
   logic        err;

   logic        s_ack;
   logic        s_err;
   logic [31:0] s_rdat;
   logic [31:0] mem [1024];
   logic        no_ack;
   logic        err_en;
   logic [31:0] err_adr;

   int          n_checks;
   int          n_errors;
   xfer_t       exp_q [$];
   vec_t        vecs [6];

   wb_copy_master_if bus ();

   wb_copy_master #(.TIMEOUT(8)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .src_adr_i (src_adr),
      .dst_adr_i (dst_adr),
      .len_i     (len_in),
      .busy_o    (busy),
      .done_o    (done),
      .err_o     (err),
      .wb        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [9:0] idx);
      if (idx < 10'd4) return 32'(idx + 10'd1) * 32'h1111_1111;
      return {16'hC0DE, 6'b0, idx};
   endfunction

   // Memory slave: acks one cycle after stb, then drops ack for one cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ack  <= 1'b0;
         s_err  <= 1'b0;
         s_rdat <= '0;
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(10'(i));
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         if (bus.wb_cyc_o && bus.wb_stb_o && !s_ack && !s_err && !no_ack) begin
            if (bus.wb_we_o) begin
               mem[bus.wb_adr_o[11:2]] <= bus.wb_dat_o;
               s_ack <= 1'b1;
            end else if (err_en && bus.wb_adr_o == err_adr) begin
               s_err <= 1'b1;
            end else begin
               s_rdat <= mem[bus.wb_adr_o[11:2]];
               s_ack  <= 1'b1;
            end
         end
      end
   end

   assign bus.wb_ack_i = s_ack;
   assign bus.wb_err_i = s_err;
   assign bus.wb_dat_i = s_rdat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare each acked bus transfer with the next expected one.
   task automatic mon();
      xfer_t x;
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected xfer: got adr 0x%0h we %0b, expected none",
                     bus.wb_adr_o, bus.wb_we_o);
         end else begin
            x = exp_q.pop_front();
            check("xfer we", 32'(bus.wb_we_o), 32'(x.we));
            check("xfer adr", bus.wb_adr_o, x.adr);
            check("xfer sel", 32'(bus.wb_sel_o), 32'h0000_000F);
            if (x.we) check("xfer wdat", bus.wb_dat_o, x.dat);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic push_words(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s;
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         s = {src[31:2], 2'b00} + 32'(4 * i);
         d = {dst[31:2], 2'b00} + 32'(4 * i);
         exp_q.push_back('{1'b0, s, 32'h0});
         exp_q.push_back('{1'b1, d, init_val(s[11:2])});
      end
   endtask

   // Start a copy, poke start once mid-transfer, and time done_o from the
   // edge that accepted start.
   task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] len, input int exp_done, input int exp_cyc,
                           input logic exp_err);
      int k;
      int cyc_n;
      src_adr = src;
      dst_adr = dst;
      len_in  = len;
      start   = 1'b1;
      step();
      start   = 1'b0;
      src_adr = 32'hFFFF_FFFF;
      dst_adr = 32'hFFFF_FFFF;
      len_in  = 16'hFFFF;
      check({name, " busy after start"}, 32'(busy), 32'h1);
      check({name, " err cleared by start"}, 32'(err), 32'h0);
      k = 0;
      cyc_n = 0;
      while (!done && k < 200) begin
         if (bus.wb_cyc_o) cyc_n++;
         if (k == 3) start = 1'b1;
         if (k == 4) start = 1'b0;
         step();
         k++;
      end
      start = 1'b0;
      check({name, " done cycle"}, 32'(k), 32'(exp_done));
      check({name, " cyc cycles"}, 32'(cyc_n), 32'(exp_cyc));
      check({name, " err_o"}, 32'(err), 32'(exp_err));
      check({name, " busy at done"}, 32'(busy), 32'h0);
      step();
      check({name, " done one cycle"}, 32'(done), 32'h0);
      check({name, " xfers outstanding"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] a_s;
      logic [31:0] a_d;
      vecs[0] = '{32'h0000_0000, 32'h0000_0400, 16'd4, 17, 16};
      vecs[1] = '{32'h0000_0010, 32'h0000_0800, 16'd1, 5, 4};
      vecs[2] = '{32'h0000_0023, 32'h0000_0601, 16'd3, 13, 12};
      vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0900, 16'd2, 9, 8};
      vecs[4] = '{32'h0000_0100, 32'h0000_0C00, 16'd0, 1, 0};
      vecs[5] = '{32'h0000_0140, 32'h0000_0C40, 16'd5, 21, 20};

      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      start    = 1'b0;
      src_adr  = '0;
      dst_adr  = '0;
      len_in   = '0;
      no_ack   = 1'b0;
      err_en   = 1'b0;
      err_adr  = 32'h0000_0204;

      repeat (3) @(posedge clk);
      #1;
      check("reset cyc", 32'(bus.wb_cyc_o), 32'h0);
      check("reset stb", 32'(bus.wb_stb_o), 32'h0);
      check("reset we", 32'(bus.wb_we_o), 32'h0);
      check("reset adr", bus.wb_adr_o, 32'h0);
      check("reset sel", 32'(bus.wb_sel_o), 32'h0);
      check("reset dat", bus.wb_dat_o, 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      check("reset err", 32'(err), 32'h0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 6; v++) begin
         push_words(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
         run_copy($sformatf("copy%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
                  vecs[v].exp_done, vecs[v].exp_cyc, 1'b0);
         for (int i = 0; i < int'(vecs[v].len); i++) begin
            a_s = {vecs[v].src[31:2], 2'b00} + 32'(4 * i);
            a_d = {vecs[v].dst[31:2], 2'b00} + 32'(4 * i);
            check($sformatf("copy%0d mem word %0d", v, i), mem[a_d[11:2]], init_val(a_s[11:2]));
         end
      end

      // Bus error on the second read: one word written, then abort.
      err_en = 1'b1;
      push_words(32'h0000_0200, 32'h0000_0A00, 1);
      run_copy("err2nd", 32'h0000_0200, 32'h0000_0A00, 16'd3, 7, 6, 1'b1);
      err_en = 1'b0;
      check("err2nd first word", mem[10'h280], init_val(10'h080));
      check("err2nd second word untouched", mem[10'h281], init_val(10'h281));
      repeat (3) step();
      check("err sticky", 32'(err), 32'h1);

      // Silent slave: abort after 8 cycles in READ.
      no_ack = 1'b1;
      run_copy("timeout", 32'h0000_0100, 32'h0000_0D00, 16'd1, 9, 8, 1'b1);
      no_ack = 1'b0;

      // Reset during the first WRITE, then a clean copy.
      exp_q.push_back('{1'b0, 32'h0000_0300, 32'h0});
      src_adr = 32'h0000_0300;
      dst_adr = 32'h0000_0B00;
      len_in  = 16'd4;
      start   = 1'b1;
      step();
      start   = 1'b0;
      step();
      step();
      check("midrst in write", 32'(bus.wb_we_o), 32'h1);
      rst = 1'b1;
      #1;
      check("midrst cyc", 32'(bus.wb_cyc_o), 32'h0);
      check("midrst stb", 32'(bus.wb_stb_o), 32'h0);
      check("midrst busy", 32'(busy), 32'h0);
      check("midrst adr", bus.wb_adr_o, 32'h0);
      check("midrst read seen", 32'(exp_q.size()), 32'h0);
      step();
      rst = 1'b0;
      step();
      check("midrst err", 32'(err), 32'h0);
      push_words(32'h0000_0300, 32'h0000_0B80, 2);
      run_copy("after_rst", 32'h0000_0300, 32'h0000_0B80, 16'd2, 9, 8, 1'b0);
      check("after_rst word0", mem[10'h2E0], init_val(10'h0C0));
      check("after_rst word1", mem[10'h2E1], init_val(10'h0C1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
